// File: rtl/fp32_add_arbiter.sv
// Arbitrates NUM_REQ requesters onto one pipelined FP32 adder and routes results back by tag.
// Define FP_ARB_RR_EN for round-robin arbitration; fixed priority (index 0 highest) otherwise.
module fp32_add_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 3,
    localparam int CW = $clog2(ADD_LATENCY + 2),
    localparam int TW = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic                  pause,
    output logic                  add_valid,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    input  logic                  add_valid_out,
    input  logic [31:0]           add_y,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_y,
    output logic [CW-1:0]         inflight,
    output logic                  idle,
    output logic                  err
);

    logic [NUM_REQ-1:0] gnt;
    logic [TW-1:0]      gnt_idx;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic               xfer;

    logic [ADD_LATENCY:0] stg_v;
    logic [TW-1:0]        stg_t [ADD_LATENCY+1];
    logic                 head_v;
    logic [NUM_REQ-1:0]   head_oh;
    logic [CW-1:0]        cnt;

`ifdef FP_ARB_RR_EN
    logic [TW-1:0] rr_ptr;
    logic [TW:0]   cand;

    // Search starts just past the last granted index and wraps.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (TW+1)'(k);
            if (cand >= (TW+1)'(NUM_REQ))
                cand = cand - (TW+1)'(NUM_REQ);
            if (gnt == '0 && req_valid[cand[TW-1:0]]) begin
                gnt[cand[TW-1:0]] = 1'b1;
                gnt_idx           = cand[TW-1:0];
            end
        end
        if (!rst_n || pause)
            gnt = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_ptr <= TW'(NUM_REQ - 1);
        else if (xfer)
            rr_ptr <= gnt_idx;
    end
`else
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt == '0 && req_valid[i]) begin
                gnt[i]  = 1'b1;
                gnt_idx = TW'(i);
            end
        end
        if (!rst_n || pause)
            gnt = '0;
    end
`endif

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    assign req_ready = gnt;
    assign xfer      = |gnt;

    // Stage 0 is the issue register; stage ADD_LATENCY lines up with add_valid_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_v <= '0;
            add_a <= '0;
            add_b <= '0;
            for (int k = 0; k <= ADD_LATENCY; k++)
                stg_t[k] <= '0;
        end else begin
            stg_v    <= {stg_v[ADD_LATENCY-1:0], xfer};
            stg_t[0] <= gnt_idx;
            for (int k = 1; k <= ADD_LATENCY; k++)
                stg_t[k] <= stg_t[k-1];
            if (xfer) begin
                add_a <= sel_a;
                add_b <= sel_b;
            end
        end
    end

    assign add_valid = stg_v[0];
    assign head_v    = stg_v[ADD_LATENCY];

    always_comb begin
        head_oh = '0;
        head_oh[stg_t[ADD_LATENCY]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_y     <= '0;
            err       <= 1'b0;
        end else begin
            if (add_valid_out && head_v) begin
                rsp_valid <= head_oh;
                rsp_y     <= add_y;
            end else begin
                rsp_valid <= '0;
            end
            if (add_valid_out != head_v)
                err <= 1'b1;
        end
    end

    // A head retire counts whether or not the adder delivered.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (xfer && !head_v)
            cnt <= cnt + 1'b1;
        else if (!xfer && head_v)
            cnt <= cnt - 1'b1;
    end

    assign inflight = cnt;
    assign idle     = (cnt == '0) && !add_valid;

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Scoreboard bench for fp32_add_arbiter with a behavioural 3-cycle FP32 adder.
module tb_fp32_add_arbiter;

    localparam int N = 4;
    localparam int L = 3;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic           pause;
    logic           add_valid;
    logic [31:0]    add_a;
    logic [31:0]    add_b;
    logic           add_valid_out;
    logic [31:0]    add_y;
    logic [N-1:0]   rsp_valid;
    logic [31:0]    rsp_y;
    logic [2:0]     inflight;
    logic           idle;
    logic           err;

    typedef struct {
        int          tag;
        logic [31:0] y;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;
    int   exp_ptr;

    logic [L-1:0] mv;
    logic [31:0]  my [L];
    logic         inject;

    fp32_add_arbiter #(.NUM_REQ(N), .ADD_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .pause(pause),
        .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
        .add_valid_out(add_valid_out), .add_y(add_y),
        .rsp_valid(rsp_valid), .rsp_y(rsp_y),
        .inflight(inflight), .idle(idle), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] f2d(input logic [31:0] f);
        if (f[30:0] == 31'd0)
            return {f[31], 63'd0};
        return {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2f(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:0] == 63'd0)
            return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        real r;
        r = $bitstoreal(f2d(a)) + $bitstoreal(f2d(b));
        return d2f($realtobits(r));
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'b0, 8'(124 + $urandom_range(0, 6)), 23'($urandom)};
    endfunction

    // Adder model: fixed latency, shares rst_n with the arbiter.
    always @(posedge clk) begin
        if (!rst_n) begin
            mv <= '0;
        end else begin
            mv    <= {mv[L-2:0], add_valid};
            my[0] <= fadd(add_a, add_b);
            for (int k = 1; k < L; k++)
                my[k] <= my[k-1];
        end
    end

    assign add_valid_out = mv[L-1] | inject;
    assign add_y         = my[L-1];

    function automatic int pick(input logic [N-1:0] v);
`ifdef FP_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (v[(exp_ptr + k) % N])
                return (exp_ptr + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i])
                return i;
        end
`endif
        return -1;
    endfunction

    task automatic note_grant(input int g, input logic [31:0] y);
        exp_t e;
        e.tag = g;
        e.y   = y;
        sb.push_back(e);
        exp_ptr = g;
    endtask

    // One clock step; any response seen is scored against the queue head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n && rsp_valid !== '0) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: rsp_valid=%b rsp_y=%h, none expected",
                         rsp_valid, rsp_y);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== N'(1 << e.tag) || rsp_y !== e.y) begin
                    n_fail++;
                    $display("FAIL rsp_match: got %b/%h, want %b/%h",
                             rsp_valid, rsp_y, N'(1 << e.tag), e.y);
                end
            end
        end
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 20 && sb.size() != 0; c++)
            tick();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d responses outstanding, want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        tick();
        tick();
        n_chk += 9;
        if (req_ready !== '0) begin
            n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready);
        end
        if (add_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_add_valid: got %b want 0", add_valid);
        end
        if (add_a !== '0) begin
            n_fail++; $display("FAIL rst_add_a: got %h want 0", add_a);
        end
        if (add_b !== '0) begin
            n_fail++; $display("FAIL rst_add_b: got %h want 0", add_b);
        end
        if (rsp_valid !== '0) begin
            n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid);
        end
        if (rsp_y !== '0) begin
            n_fail++; $display("FAIL rst_rsp_y: got %h want 0", rsp_y);
        end
        if (inflight !== '0) begin
            n_fail++; $display("FAIL rst_inflight: got %0d want 0", inflight);
        end
        if (idle !== 1'b1) begin
            n_fail++; $display("FAIL rst_idle: got %b want 1", idle);
        end
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL rst_err: got %b want 0", err);
        end
        req_valid = '0;
        rst_n     = 1'b1;
        exp_ptr   = N - 1;
        sb.delete();
        tick();
    endtask

    task automatic test_single();
        req_a[31:0] = 32'h3F80_0000;
        req_b[31:0] = 32'h4000_0000;
        req_valid   = 4'b0001;
        #1;
        n_chk++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        note_grant(0, 32'h4040_0000);
        tick();
        req_valid = '0;
        n_chk += 4;
        if (add_valid !== 1'b1 || add_a !== 32'h3F80_0000 || add_b !== 32'h4000_0000) begin
            n_fail++;
            $display("FAIL single_issue: got v=%b a=%h b=%h want 1/3f800000/40000000",
                     add_valid, add_a, add_b);
        end
        if (inflight !== 3'd1) begin
            n_fail++; $display("FAIL single_inflight1: got %0d want 1", inflight);
        end
        if (idle !== 1'b0) begin
            n_fail++; $display("FAIL single_busy: got idle=%b want 0", idle);
        end
        if (rsp_valid !== '0) begin
            n_fail++; $display("FAIL single_early0: got %b want 0", rsp_valid);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_chk++;
            if (k < 4) begin
                if (rsp_valid !== '0) begin
                    n_fail++; $display("FAIL single_early: edge %0d got %b want 0", k, rsp_valid);
                end
            end else begin
                if (rsp_valid !== 4'b0001 || rsp_y !== 32'h4040_0000 ||
                    inflight !== 3'd0 || idle !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_rsp: got %b/%h inflight=%0d idle=%b want 0001/40400000/0/1",
                             rsp_valid, rsp_y, inflight, idle);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        logic [N-1:0] v;
        int           g;
        logic [31:0]  y;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = (i == 2) ? 32'h4040_0000 : rnd_fp();
            req_b[32*i +: 32] = (i == 2) ? 32'h3F80_0000 : rnd_fp();
        end
        for (int c = 0; c < 9; c++) begin
            v = (c < 8) ? 4'b1111 : 4'b1100;
            req_valid = v;
            #1;
            g = pick(v);
            n_chk++;
            if (req_ready !== N'(1 << g)) begin
                n_fail++; $display("FAIL arb_grant: cycle %0d got %b want %b",
                                   c, req_ready, N'(1 << g));
            end
            y = (g == 2) ? 32'h4080_0000 : fadd(req_a[32*g +: 32], req_b[32*g +: 32]);
            note_grant(g, y);
            tick();
        end
        req_valid = '0;
        drain("arb");
    endtask

    task automatic test_back_to_back();
        int first, last, hits, peak;
        first = -1;
        last  = -1;
        hits  = 0;
        peak  = 0;
        for (int c = 0; c < 16; c++) begin
            if (c < 10) begin
                req_a[63:32] = rnd_fp();
                req_b[63:32] = rnd_fp();
                req_valid    = 4'b0010;
                #1;
                n_chk++;
                if (req_ready !== 4'b0010) begin
                    n_fail++; $display("FAIL b2b_ready: cycle %0d got %b want 0010", c, req_ready);
                end
                note_grant(1, fadd(req_a[63:32], req_b[63:32]));
            end else begin
                req_valid = '0;
            end
            tick();
            if (int'(inflight) > peak)
                peak = int'(inflight);
            if (rsp_valid === 4'b0010) begin
                if (first < 0)
                    first = c;
                last = c;
                hits++;
            end
        end
        n_chk += 2;
        if (hits != 10 || last - first != 9) begin
            n_fail++; $display("FAIL b2b_stream: got %0d rsps over %0d cycles want 10 over 10",
                               hits, last - first + 1);
        end
        if (peak != 4) begin
            n_fail++; $display("FAIL b2b_peak: got %0d want 4", peak);
        end
        drain("b2b");
    endtask

    task automatic test_pause();
        int blocked_bad;
        blocked_bad = 0;
        for (int c = 0; c < 3; c++) begin
            req_a[127:96] = rnd_fp();
            req_b[127:96] = rnd_fp();
            req_valid     = 4'b1000;
            #1;
            n_chk++;
            if (req_ready !== 4'b1000) begin
                n_fail++; $display("FAIL pause_issue: cycle %0d got %b want 1000", c, req_ready);
            end
            note_grant(3, fadd(req_a[127:96], req_b[127:96]));
            tick();
        end
        pause = 1'b1;
        #1;
        n_chk += 2;
        if (req_ready !== '0) begin
            n_fail++; $display("FAIL pause_block: got %b want 0", req_ready);
        end
        if (inflight !== 3'd3) begin
            n_fail++; $display("FAIL pause_inflight: got %0d want 3", inflight);
        end
        for (int c = 0; c < 10 && !(idle === 1'b1 && sb.size() == 0); c++) begin
            tick();
            if (req_ready !== '0)
                blocked_bad++;
        end
        n_chk += 3;
        if (blocked_bad != 0) begin
            n_fail++; $display("FAIL pause_hold: got %0d granted cycles want 0", blocked_bad);
        end
        if (idle !== 1'b1) begin
            n_fail++; $display("FAIL pause_idle: got %b want 1", idle);
        end
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL pause_drain: got %0d outstanding want 0", sb.size());
        end
        pause     = 1'b0;
        req_valid = '0;
        tick();
    endtask

    task automatic test_error();
        n_chk++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL err_clean: got %b want 0", err);
        end
        inject = 1'b1;
        tick();
        inject = 1'b0;
        n_chk += 2;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL err_set: got %b want 1", err);
        end
        if (rsp_valid !== '0) begin
            n_fail++; $display("FAIL err_dropped: got %b want 0", rsp_valid);
        end
        tick();
        tick();
        tick();
        n_chk++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        req_a[31:0]  = rnd_fp();
        req_b[31:0]  = rnd_fp();
        req_valid    = 4'b0001;
        tick();
        req_a[95:64] = rnd_fp();
        req_b[95:64] = rnd_fp();
        req_valid    = 4'b0100;
        tick();
        req_valid = '0;
        n_chk++;
        if (inflight !== 3'd2) begin
            n_fail++; $display("FAIL rmid_inflight: got %0d want 2", inflight);
        end
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n   = 1'b1;
        exp_ptr = N - 1;
        n_chk += 3;
        if (add_valid !== 1'b0 || add_a !== '0 || add_b !== '0) begin
            n_fail++; $display("FAIL rmid_issue: got %b/%h/%h want 0/0/0", add_valid, add_a, add_b);
        end
        if (rsp_valid !== '0 || rsp_y !== '0) begin
            n_fail++; $display("FAIL rmid_rsp: got %b/%h want 0/0", rsp_valid, rsp_y);
        end
        if (inflight !== '0 || idle !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL rmid_state: got inflight=%0d idle=%b err=%b want 0/1/0",
                               inflight, idle, err);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            if (rsp_valid !== '0)
                stray++;
        end
        n_chk += 2;
        if (stray != 0 || err !== 1'b0) begin
            n_fail++; $display("FAIL rmid_quiet: got %0d rsps err=%b want 0/0", stray, err);
        end
        req_valid = '1;
        #1;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rmid_first_grant: got %b want 0001", req_ready);
        end
        req_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        exp_ptr   = N - 1;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        pause     = 1'b0;
        inject    = 1'b0;
        test_reset();
        test_single();
        test_arbitration();
        test_back_to_back();
        test_pause();
        test_error();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
